step_ctrl: RTL
==============

Name: step_ctrl

Overview:
- Sequencer for the 9-state ID-digit fsm. Generates that fsm's data_in as single-cycle advance pulses.
- Arbitrates three advance sources:
  - manual: debounced push-button
  - auto: periodic tick
  - seek: run until fsm current_state equals a target
- Sits between board inputs and the fsm. Reads back the fsm's current_state to close the loop.

Parameters:
- TICK_DIV, 50000000, clk cycles between auto advances (>=2)
- DEBOUNCE_CYC, 1000000, cycles btn_step must be stable before it is accepted (>=1)
- NUM_STATES, 9, number of fsm states; valid encodings are 0..NUM_STATES-1
- CNT_W, 8, width of step_count

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- btn_step  input  1  raw, asynchronous push-button
- mode  input  2  00 idle, 01 manual, 10 auto, 11 seek
- seek_start  input  1  single-cycle request to begin a seek (honoured in mode 11 only)
- target_state  input  4  seek target, sampled on the seek_start cycle
- fsm_state  input  4  current_state fed back from the fsm
- advance  output  1  single-cycle pulse, drives fsm data_in
- busy  output  1  high while the controller is not in IDLE
- seek_done  output  1  single-cycle pulse when fsm_state equals target
- seek_err  output  1  sticky; cleared by the next accepted seek_start or by reset
- step_count  output  CNT_W  total advances issued, wraps at max

Behaviour:
- Reset (synchronous, active-high): controller to IDLE; advance=0, busy=0, seek_done=0, seek_err=0, step_count=0; tick counter and debouncer cleared. Reset mid-pulse or mid-seek aborts with no further advances.
- States: IDLE, MAN, AUTO, SEEK_ISSUE, SEEK_WAIT, GAP.
- IDLE:
  - mode 01 -> MAN.
  - mode 10 -> AUTO, tick counter cleared.
  - mode 11 with seek_start -> latch target, clear seek_err, then:
    - target >= NUM_STATES: set seek_err, stay IDLE, no advance.
    - target == fsm_state: seek_done the next cycle, zero advances.
    - otherwise -> SEEK_ISSUE.
- MAN: each debounced rising edge of btn_step gives one advance (cycle n), then GAP (cycle n+1), then back to MAN. If mode != 01, return to IDLE.
- AUTO: tick counter counts 0..TICK_DIV-1. Terminal count gives advance, counter returns to 0. Button edges are ignored. If mode != 10, go to IDLE; any pulse already issued still completes.
- SEEK_ISSUE: advance for 1 cycle, increment the seek advance counter, then SEEK_WAIT.
- SEEK_WAIT: one-cycle wait, because the fsm registers data_in and fsm_state is valid 1 cycle after the pulse. Then compare:
  - equal: seek_done pulse, go to IDLE.
  - not equal and seek advances < NUM_STATES: SEEK_ISSUE.
  - not equal and seek advances == NUM_STATES (e.g. fsm reset externally): seek_err=1, go to IDLE.
- Seek is not abortable by a mode change; only reset aborts it. seek_start while busy is ignored.
- Spacing: consecutive advance pulses are at least 2 cycles apart in every mode.
- step_count: +1 on every advance cycle, modulo 2^CNT_W (0xFF -> 0x00 for CNT_W=8).
- busy = state != IDLE.

Optional Feature:
- Macro: STEP_CTRL_AUTO_LAP_EN.
- Defined:
  - In AUTO, after an advance, if fsm_state returns to 0 the controller goes to IDLE. This completes one lap of the ID sequence.
  - It asserts output lap_done (1 bit) as a single-cycle pulse in the compare cycle.
  - mode must leave 10 and re-enter before auto restarts.
- Undefined: AUTO runs indefinitely; the lap_done port does not exist.

Decomposition:
- Package step_ctrl_pkg:
  - mode encodings MODE_IDLE/MODE_MAN/MODE_AUTO/MODE_SEEK
  - controller state enum
  - default NUM_STATES
- Sub-module btn_debounce:
  - 2-flop synchronizer
  - stability counter of DEBOUNCE_CYC
  - registered rising-edge pulse output
  - same clk/reset

Test Plan (TICK_DIV=4, DEBOUNCE_CYC=3, fsm model attached):
- Reset held 2 cycles mid-AUTO -> advance=0, busy=0, step_count=0 on the cycle after reset deasserts.
- Manual mode:
  - btn_step glitch of 2 cycles -> no advance.
  - clean 10-cycle press -> exactly one advance; fsm_state 0->1; step_count=1.
- Auto mode for 20 cycles from state 0 -> advances at cycles 4,8,12,16,20; fsm_state=5; button pulses ignored.
- Seek, fsm_state=7, target=2:
  - advances 7->8->0->1->2 with 2-cycle spacing, then seek_done.
  - 4 advances total; seek_err=0.
- Seek target=9 -> seek_err=1, zero advances. Seek target equal to current -> seek_done next cycle, zero advances, seek_err cleared.
- Seek with the fsm model held in reset -> 9 advances, then seek_err=1, busy=0. With STEP_CTRL_AUTO_LAP_EN: auto from 0 -> 9 advances, lap_done, then IDLE.

Source files
------------

// File: rtl/step_ctrl_pkg.sv
// step_ctrl shared definitions: mode encodings, controller states,
// and the default length of the ID-digit sequence.
package step_ctrl_pkg;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_MAN  = 2'b01;
    localparam logic [1:0] MODE_AUTO = 2'b10;
    localparam logic [1:0] MODE_SEEK = 2'b11;

    localparam int DEF_NUM_STATES = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAN,
        ST_AUTO,
        ST_SEEK_ISSUE,
        ST_SEEK_WAIT,
        ST_GAP
    } ctrl_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter,
// and a registered single-cycle pulse on each accepted rising edge.
module btn_debounce
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync0;
    logic          sync1;
    logic          level;
    logic [CW-1:0] cnt;

    // bring the raw button into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= btn;
            sync1 <= sync0;
        end
    end

    // accept a new level only after it has held for DEBOUNCE_CYC cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync1;
                rise  <= sync1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// Advance-pulse sequencer for the ID-digit fsm (manual/auto/seek).
// Build option STEP_CTRL_AUTO_LAP_EN: auto mode stops after one lap.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int TICK_DIV     = 50000000,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int NUM_STATES   = DEF_NUM_STATES,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_step,
    input  logic [1:0]       mode,
    input  logic             seek_start,
    input  logic [3:0]       target_state,
    input  logic [3:0]       fsm_state,
    output logic             advance,
    output logic             busy,
    output logic             seek_done,
    output logic             seek_err,
    output logic [CNT_W-1:0] step_count
`ifdef STEP_CTRL_AUTO_LAP_EN
    ,
    output logic             lap_done
`endif
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam int SW = $clog2(NUM_STATES + 1);
    localparam logic [SW-1:0] SEEK_MAX = SW'(NUM_STATES);

    ctrl_state_t   state;
    ctrl_state_t   state_nxt;
    logic [TW-1:0] tick;
    logic [3:0]    target_q;
    logic [SW-1:0] seek_cnt;
    logic          btn_rise;
    logic          seek_go;
    logic          err_set;
    logic          tgt_bad;
    logic          auto_ok;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_step),
        .rise (btn_rise)
    );

    assign tgt_bad = {28'd0, target_state} >= 32'(NUM_STATES);
    assign busy    = (state != ST_IDLE);

`ifdef STEP_CTRL_AUTO_LAP_EN
    logic adv_d;
    logic lap_lock;

    // remember the auto advance and hold auto off until mode re-enters
    always_ff @(posedge clk) begin
        if (reset) begin
            adv_d    <= 1'b0;
            lap_lock <= 1'b0;
        end else begin
            adv_d <= advance && (state == ST_AUTO);
            if (lap_done) begin
                lap_lock <= 1'b1;
            end else if (mode != MODE_AUTO) begin
                lap_lock <= 1'b0;
            end
        end
    end

    assign auto_ok = !lap_lock;
`else
    assign auto_ok = 1'b1;
`endif

    // controller state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state, advance pulse and seek strobes
    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        seek_done = 1'b0;
        seek_go   = 1'b0;
        err_set   = 1'b0;
`ifdef STEP_CTRL_AUTO_LAP_EN
        lap_done  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (mode == MODE_MAN) begin
                    state_nxt = ST_MAN;
                end else if (mode == MODE_AUTO && auto_ok) begin
                    state_nxt = ST_AUTO;
                end else if (mode == MODE_SEEK && seek_start) begin
                    seek_go = 1'b1;
                    if (tgt_bad) begin
                        err_set = 1'b1;
                    end else if (target_state == fsm_state) begin
                        state_nxt = ST_SEEK_WAIT;
                    end else begin
                        state_nxt = ST_SEEK_ISSUE;
                    end
                end
            end
            ST_MAN: begin
                if (mode != MODE_MAN) begin
                    state_nxt = ST_IDLE;
                end else if (btn_rise) begin
                    advance   = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                state_nxt = (mode == MODE_MAN) ? ST_MAN : ST_IDLE;
            end
            ST_AUTO: begin
`ifdef STEP_CTRL_AUTO_LAP_EN
                if (adv_d && fsm_state == 4'd0) begin
                    lap_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end else
`endif
                if (mode != MODE_AUTO) begin
                    state_nxt = ST_IDLE;
                end else if (tick == TICK_LAST) begin
                    advance = 1'b1;
                end
            end
            ST_SEEK_ISSUE: begin
                advance   = 1'b1;
                state_nxt = ST_SEEK_WAIT;
            end
            ST_SEEK_WAIT: begin
                if (fsm_state == target_q) begin
                    seek_done = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (seek_cnt < SEEK_MAX) begin
                    state_nxt = ST_SEEK_ISSUE;
                end else begin
                    err_set   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // auto tick divider, held at zero outside AUTO
    always_ff @(posedge clk) begin
        if (reset || state != ST_AUTO) begin
            tick <= '0;
        end else if (tick == TICK_LAST) begin
            tick <= '0;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    // seek target, advance budget and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            target_q <= 4'd0;
            seek_cnt <= '0;
            seek_err <= 1'b0;
        end else if (seek_go) begin
            target_q <= target_state;
            seek_cnt <= '0;
            seek_err <= err_set;
        end else begin
            if (state == ST_SEEK_ISSUE) begin
                seek_cnt <= seek_cnt + 1'b1;
            end
            if (err_set) begin
                seek_err <= 1'b1;
            end
        end
    end

    // running total of advances, wrapping at 2^CNT_W
    always_ff @(posedge clk) begin
        if (reset) begin
            step_count <= '0;
        end else if (advance) begin
            step_count <= step_count + 1'b1;
        end
    end

endmodule
